// File: rtl/weightmemory_writer_if.sv
// Bus bundle between weightmemory_writer, its upstream trit stream and one weightmemory bank write port.
interface weightmemory_writer_if #(
    parameter int AW         = 5,
    parameter int BEAT_TRITS = 8,
    parameter int WBITS      = 104
);
    logic                        start_i;
    logic [AW-1:0]               base_addr_i;
    logic [AW:0]                 num_words_i;
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [0:BEAT_TRITS-1][1:0]  in_trits_i;
    logic                        mem_gnt_i;
    logic                        write_enable_o;
    logic [AW-1:0]               addr_o;
    logic [WBITS-1:0]            wdata_o;
    logic                        busy_o;
    logic                        done_o;
    logic                        error_o;

    modport master (
        output start_i, base_addr_i, num_words_i, in_valid_i, in_trits_i, mem_gnt_i,
        input  in_ready_o, write_enable_o, addr_o, wdata_o, busy_o, done_o, error_o
    );

    modport slave (
        input  start_i, base_addr_i, num_words_i, in_valid_i, in_trits_i, mem_gnt_i,
        output in_ready_o, write_enable_o, addr_o, wdata_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/weightmemory_writer.sv
// Packs streamed ternary weights 5 trits -> 8 bits and writes them to consecutive weightmemory addresses.
// Optional illegal-code checking: define WEIGHTMEMORY_WRITER_TRITCHECK_EN.
module weightmemory_writer #(
    parameter int N_I            = 512,
    parameter int WEIGHT_STAGGER = 8,
    parameter int BANKDEPTH      = 32,
    parameter int BEAT_TRITS     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    weightmemory_writer_if.slave bus
);
    localparam int EFF    = N_I / WEIGHT_STAGGER;
    localparam int NENC   = (EFF + 4) / 5;
    localparam int PHYS   = NENC * 5;
    localparam int PAD    = PHYS - EFF;
    localparam int WBITS  = NENC * 8;
    localparam int NBEATS = EFF / BEAT_TRITS;
    localparam int AW     = $clog2(BANKDEPTH);
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                     state;
    logic [BW-1:0]              beat_cnt;
    logic [AW:0]                words_left;
    logic [AW-1:0]              addr_q;
    logic [WBITS-1:0]           wdata_q;
    logic [EFF-1:0][1:0]        trit_buf;
    logic                       in_ready_q;
    logic                       we_q;
    logic                       busy_q;
    logic                       done_q;

    logic [0:BEAT_TRITS-1][1:0] beat_clean;
    logic [PHYS-1:0][1:0]       flat;
    logic [WBITS-1:0]           wdata_next;

    // Trit digit: -1 -> 0, 0 -> 1, +1 -> 2; slot k of an encoder carries weight 3^k.
    function automatic logic [7:0] trit_digit(input logic [1:0] code);
        case (code)
            2'b11:   return 8'd0;
            2'b01:   return 8'd2;
            default: return 8'd1;
        endcase
    endfunction

    function automatic logic [7:0] enc5(input logic [4:0][1:0] slots);
        logic [7:0] acc;
        acc = '0;
        for (int k = 4; k >= 0; k--) begin
            acc = acc * 8'd3 + trit_digit(slots[k]);
        end
        return acc;
    endfunction

`ifdef WEIGHTMEMORY_WRITER_TRITCHECK_EN
    logic beat_illegal;
    logic error_q;

    always_comb begin
        beat_clean   = bus.in_trits_i;
        beat_illegal = 1'b0;
        for (int k = 0; k < BEAT_TRITS; k++) begin
            if (bus.in_trits_i[k] == 2'b10) begin
                beat_clean[k] = 2'b00;
                beat_illegal  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            error_q <= 1'b0;
        end else if (state == IDLE && bus.start_i) begin
            error_q <= 1'b0;
        end else if (state == FILL && bus.in_valid_i && beat_illegal) begin
            error_q <= 1'b1;
        end
    end

    assign bus.error_o = error_q;
`else
    always_comb begin
        beat_clean = bus.in_trits_i;
    end

    assign bus.error_o = 1'b0;
`endif

    // The incoming beat is overlaid on the buffer so the last beat can be encoded in its own cycle.
    always_comb begin
        flat = '0;
        for (int t = 0; t < EFF; t++) begin
            if (BW'(t / BEAT_TRITS) == beat_cnt) begin
                flat[t + PAD] = beat_clean[t % BEAT_TRITS];
            end else begin
                flat[t + PAD] = trit_buf[t];
            end
        end
    end

    always_comb begin
        wdata_next = '0;
        for (int n = 0; n < NENC; n++) begin
            wdata_next[8*n +: 8] = enc5(flat[5*n +: 5]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            words_left <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            trit_buf   <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        addr_q     <= bus.base_addr_i;
                        words_left <= bus.num_words_i;
                        beat_cnt   <= '0;
                        busy_q     <= 1'b1;
                        if (bus.num_words_i == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state      <= FILL;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (bus.in_valid_i) begin
                        trit_buf <= flat[PHYS-1:PAD];
                        if (beat_cnt == BW'(NBEATS - 1)) begin
                            beat_cnt   <= '0;
                            wdata_q    <= wdata_next;
                            state      <= WRITE;
                            in_ready_q <= 1'b0;
                            we_q       <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_gnt_i) begin
                        we_q       <= 1'b0;
                        addr_q     <= (addr_q == AW'(BANKDEPTH - 1)) ? '0 : addr_q + 1'b1;
                        words_left <= words_left - 1'b1;
                        if (words_left == (AW+1)'(1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state      <= FILL;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o     = in_ready_q;
    assign bus.write_enable_o = we_q;
    assign bus.addr_o         = addr_q;
    assign bus.wdata_o        = wdata_q;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
endmodule
